// File: rtl/sp_mem_responder.sv
// Round-robin arbiter in front of a single-port 16-bit memory serving N_CORES request ports, one access at a time; ack follows grant by 3 edges.
// Cores hold req until ack. Defining SPMEM_BOUNDS_CHECK_EN blocks out-of-range accesses and flags them on err.
module sp_mem_responder #(
  parameter int N_CORES    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CORES-1:0]    req,
  input  logic [N_CORES-1:0]    we,
  input  logic [16*N_CORES-1:0] addr,
  input  logic [16*N_CORES-1:0] wdata,
  output logic [16*N_CORES-1:0] rdata,
  output logic [N_CORES-1:0]    ack,
  output logic                  err
);

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      g_q;
  logic               we_q;
  logic [15:0]        addr_q;
  logic [15:0]        wdata_q;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic [N_CORES-1:0] elig;
  logic               in_range;
  logic [15:0]        mem [0:(1<<DEPTH_LOG2)-1];

`ifdef SPMEM_BOUNDS_CHECK_EN
  assign in_range = ((addr_q >> DEPTH_LOG2) == 16'd0);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^(addr_q >> DEPTH_LOG2);
  assign in_range       = 1'b1;
`endif

  // ack is high only in the IDLE cycle right after RESP, so it masks the core just served
  assign elig = req & ~ack;

  always_comb begin
    logic [IW:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_CORES)) cand = cand - (IW+1)'(N_CORES);
      if (elig[cand[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      g_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack     <= '0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ack <= '0;
          err <= 1'b0;
          if (gnt_vld) begin
            g_q     <= gnt_idx;
            we_q    <= we[gnt_idx];
            addr_q  <= addr[{gnt_idx, 4'h0} +: 16];
            wdata_q <= wdata[{gnt_idx, 4'h0} +: 16];
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!we_q) begin
            rdata[{g_q, 4'h0} +: 16] <= in_range ? mem[addr_q[DEPTH_LOG2-1:0]] : 16'h0000;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          for (int i = 0; i < N_CORES; i++) begin
            ack[i] <= (g_q == i[IW-1:0]);
          end
          err    <= ~in_range;
          rr_ptr <= (g_q == IW'(N_CORES - 1)) ? '0 : g_q + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory has no reset; a reset on the ACCESS edge cancels the store
  always_ff @(posedge clk) begin
    if (!reset && state == S_ACCESS && we_q && in_range) begin
      mem[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_sp_mem_responder.sv
// Bench for sp_mem_responder: transaction-level model checked every cycle plus directed literal checks.
module tb_sp_mem_responder;
  localparam int N = 4;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   we;
  logic [16*N-1:0] addr;
  logic [16*N-1:0] wdata;
  logic [16*N-1:0] rdata;
  logic [N-1:0]   ack;
  logic           err;

  sp_mem_responder #(.N_CORES(N), .DEPTH_LOG2(D)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Model: a granted transaction takes effect on memory one edge later and is acked the edge after
  logic [15:0] m_mem [0:(1<<D)-1];
  logic [15:0] m_rdata [N];
  logic [N-1:0] m_ack;
  logic        m_err;
  int          m_active, m_age, m_g, m_rr, m_excl, pick, cnd;
  logic        m_we;
  logic [15:0] m_addr, m_wdata;

  function automatic bit in_rng(input logic [15:0] a);
`ifdef SPMEM_BOUNDS_CHECK_EN
    return (a >> D) == 16'd0;
`else
    return (a != a) || 1'b1;
`endif
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_ack = '0; m_err = 1'b0; m_rr = 0; m_active = 0; m_age = 0; m_excl = -1;
      for (int i = 0; i < N; i++) m_rdata[i] = 16'h0000;
    end else begin
      m_ack = '0;
      m_err = 1'b0;
      if (m_active != 0) begin
        m_age++;
        if (m_age == 1) begin
          if (in_rng(m_addr)) begin
            if (m_we) m_mem[m_addr[D-1:0]] = m_wdata;
            else      m_rdata[m_g] = m_mem[m_addr[D-1:0]];
          end else if (!m_we) begin
            m_rdata[m_g] = 16'h0000;
          end
        end else begin
          m_ack[m_g] = 1'b1;
          m_err      = !in_rng(m_addr);
          m_rr       = (m_g + 1) % N;
          m_excl     = m_g;
          m_active   = 0;
        end
      end else begin
        pick = -1;
        for (int k = N - 1; k >= 0; k--) begin
          cnd = (m_rr + k) % N;
          if (req[cnd] && cnd != m_excl) pick = cnd;
        end
        m_excl = -1;
        if (pick >= 0) begin
          m_active = 1; m_age = 0; m_g = pick;
          m_we = we[pick]; m_addr = addr[16*pick +: 16]; m_wdata = wdata[16*pick +: 16];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (ack !== m_ack) begin
        errors++;
        $display("FAIL ack @%0d: got %b expected %b", cyc, ack, m_ack);
      end
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("FAIL err @%0d: got %b expected %b", cyc, err, m_err);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (rdata[16*i +: 16] !== m_rdata[i]) begin
          errors++;
          $display("FAIL rdata[%0d] @%0d: got %h expected %h", i, cyc, rdata[16*i +: 16], m_rdata[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input int c, input bit w, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output bit e_seen);
    int n;
    @(negedge clk);
    req[c] = 1'b1; we[c] = w; addr[16*c +: 16] = a; wdata[16*c +: 16] = d;
    n = 0;
    while (!ack[c] && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat    = n;
    e_seen = err;
    if (!ack[c]) begin
      checks++;
      errors++;
      $display("FAIL ack timeout core %0d: got no ack expected ack within 40 cycles", c);
    end
    // hold req one extra cycle, as a slow core would
    @(negedge clk);
    req[c] = 1'b0;
  endtask

  int ackc [N];
  int lat, t0, cnt;
  bit e;

  task automatic run_parallel(input logic [N-1:0] mask, input int base_addr);
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < N; i++) begin
      ackc[i] = -1;
      if (mask[i]) begin
        we[i] = 1'b0; addr[16*i +: 16] = 16'(base_addr + i); req[i] = 1'b1;
      end
    end
    for (int n = 0; n < 40 && req != '0; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack[i] && req[i]) begin
          ackc[i] = cyc;
          req[i]  = 1'b0;
        end
      end
    end
    if (req != '0) begin
      checks++;
      errors++;
      $display("FAIL parallel timeout: got req %b pending expected all acked", req);
      req = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset ack", 64'(ack), 64'h0);
    chk("reset err", 64'(err), 64'h0);
    chk("reset rdata", rdata, 64'h0);
    reset = 1'b0;

    // store then load, fixed 3-cycle latency
    do_req(0, 1'b1, 16'h0012, 16'hBEEF, lat, e);
    chk("store latency", 64'(lat), 64'd3);
    do_req(0, 1'b0, 16'h0012, 16'h0000, lat, e);
    chk("load latency", 64'(lat), 64'd3);
    chk("load BEEF", 64'(rdata[15:0]), 64'hBEEF);

    for (int i = 0; i < N; i++) do_req(0, 1'b1, 16'(16'h0020 + i), 16'(16'h1000 + i), lat, e);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;

    // all cores at once after reset: served 0,1,2,3 three cycles apart
    run_parallel(4'b1111, 16'h0020);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rr ack time core%0d", i), 64'(ackc[i] - t0), 64'(3 * (i + 1)));
      chk($sformatf("rr rdata core%0d", i), 64'(rdata[16*i +: 16]), 64'(16'h1000 + i));
    end
    // pointer wrapped to 0: core 0 beats core 3
    run_parallel(4'b1001, 16'h0020);
    chk("wrap first core0", 64'(ackc[0] - t0), 64'd3);
    chk("wrap second core3", 64'(ackc[3] - t0), 64'd6);

    // core 2 drops req right after grant
    @(negedge clk);
    we[2] = 1'b0; addr[47:32] = 16'h0012; req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[2]) cnt++;
    end
    chk("drop req ack count", 64'(cnt), 64'd1);
    chk("drop req rdata2", 64'(rdata[47:32]), 64'hBEEF);

    // reset during ACCESS of a core-1 store
    do_req(1, 1'b1, 16'h0040, 16'h1111, lat, e);
    @(negedge clk);
    we[1] = 1'b1; addr[31:16] = 16'h0040; wdata[31:16] = 16'h1234; req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("abort ack", 64'(ack), 64'h0);
    chk("abort err", 64'(err), 64'h0);
    chk("abort rdata", rdata, 64'h0);
    reset = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack != '0) cnt++;
    end
    chk("abort no ack", 64'(cnt), 64'd0);
    do_req(1, 1'b0, 16'h0040, 16'h0000, lat, e);
    chk("abort store suppressed", 64'(rdata[31:16]), 64'h1111);

    // out-of-range address
    do_req(0, 1'b1, 16'h0005, 16'h5A5A, lat, e);
    do_req(0, 1'b0, 16'h0105, 16'h0000, lat, e);
`ifdef SPMEM_BOUNDS_CHECK_EN
    chk("oob rdata", 64'(rdata[15:0]), 64'h0000);
    chk("oob err", 64'(e), 64'd1);
`else
    chk("wrap rdata", 64'(rdata[15:0]), 64'h5A5A);
    chk("wrap err", 64'(e), 64'd0);
`endif

    // core 3 loads while core 1 keeps storing elsewhere
    do_req(3, 1'b1, 16'h00AA, 16'hC3C3, lat, e);
    fork
      begin
        int l1; bit e1;
        for (int k = 0; k < 4; k++) do_req(1, 1'b1, 16'(16'h0010 + k), 16'(16'h7000 + k), l1, e1);
      end
      begin
        int l3; bit e3;
        do_req(3, 1'b0, 16'h00AA, 16'h0000, l3, e3);
        do_req(3, 1'b0, 16'h00AA, 16'h0000, l3, e3);
      end
    join
    chk("stable rdata3", 64'(rdata[63:48]), 64'hC3C3);
    chk("stores keep rdata1", 64'(rdata[31:16]), 64'h1111);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
